pwm_sample_scaler: RTL
======================

// Module: pwm_sample_scaler
// PURPOSE
//  Multi-channel successor to the PWM audio sample reducer: takes signed PCM samples tagged with a channel.
//  Per channel, it produces sign-magnitude safe, attenuated, saturated samples for the PWM modulators.
//  Sits between the sample source (mixer/decoder) and the per-channel PWM generators.
//  Adds per-channel gain shift, output width change, clip/overrun reporting and a busy handshake.
// PARAMETERS
//  IN_W     16  input sample width, two's complement
//  OUT_W    16  output sample width, two's complement (may be < or >= IN_W)
//  NCH      2   number of channels; CH_W = max(1,$clog2(NCH))
//  SHIFT_W  4   width of each per-channel attenuation shift field
// PORTS
//  clk          in   1             clock
//  rst          in   1             synchronous reset, active-low (0 = reset)
//  sound_in     in   IN_W          signed input sample
//  sound_ch     in   CH_W          channel tag of sound_in
//  sound_rdy    in   1             input strobe, sampled only when busy=0
//  gain_shift   in   NCH*SHIFT_W   per-channel right shift, ch k at [k*SHIFT_W +: SHIFT_W]
//  busy         out  1             1 while a sample is in flight (state != IDLE)
//  reduced_out  out  OUT_W         signed scaled sample, valid only with reduced_rdy
//  reduced_ch   out  CH_W          channel tag of reduced_out
//  reduced_rdy  out  1             one-cycle valid pulse
//  clip         out  1             1 with reduced_rdy if this sample saturated
//  overrun      out  1             sticky: sound_rdy seen while busy=1; cleared only by reset
// BEHAVIOUR
//  - Reset (rst=0 at edge): state IDLE; all outputs 0; in-flight sample discarded, no reduced_rdy emitted.
//  - FSM IDLE->MAG->SCALE->OUT->IDLE, one cycle per state, no stalls.
//  - IDLE: on sound_rdy, capture sample, channel and that channel's gain_shift; go to MAG.
//    gain_shift changes after capture do not affect the in-flight sample.
//  - MAG: sign bit latched; magnitude = |x|. The value -2^(IN_W-1) maps to 2^(IN_W-1)-1 and sets clip.
//  - SCALE: mag >> shift. shift >= IN_W gives 0. Then saturate to 2^(OUT_W-1)-1 (sets clip).
//    If OUT_W > IN_W, zero-extend.
//  - OUT: reduced_out = sign ? -mag : mag; reduced_rdy=1, reduced_ch, clip valid this cycle only.
//    A zero magnitude always yields 0, never -0.
//  - Latency: sound_rdy accepted at edge k -> reduced_rdy high in the cycle after edge k+3.
//    Throughput is 1 sample / 4 cycles.
//  - sound_rdy while busy=1: sample dropped, overrun set; it is not queued. In OUT, busy=1, so it is dropped.
//  - sound_ch >= NCH: sample dropped silently (no overrun, no output).
//  - Outside the OUT cycle: reduced_out, reduced_ch and clip are held at 0.
// CONFIGURATION
//  PWM_SCALER_ROUND_EN defined: SCALE rounds half-up on magnitude, i.e. (mag + (1<<(shift-1))) >> shift.
//    Applies for shift in 1..IN_W-1; the carry saturates per the rules above and sets clip.
//  Undefined: plain truncation of magnitude (round toward zero on signed value).
// STRUCTURE
//  Shared package pwm_audio_pkg: FSM state enum (IDLE,MAG,SCALE,OUT) and CH_W/clog2 helper.
//  Sub-module pwm_sat_abs: combinational |x| with most-negative saturation, parametrised by IN_W.
// TESTING (IN_W=16, OUT_W=16, NCH=2 unless noted)
//  1. ch0, shift 0, in 0x8000 -> out 0x8001, clip=1, rdy 4th cycle after accept.
//  2. ch1, shift 2, in 0x4000 -> out 0x1000, reduced_ch=1, clip=0; in 0xC000 -> 0xF000.
//  3. ch0, shift 1, in 0xFFFF -> out 0x0000 (truncation); with PWM_SCALER_ROUND_EN -> 0xFFFF.
//  4. OUT_W=8, shift 0, in 0x0123 -> out 0x7F, clip=1; in 0xFF80 -> 0x80 path gives 0x81, clip=1.
//  5. sound_rdy pulsed at accept+1 -> second sample dropped, overrun=1 stays 1 until rst=0.
//  6. rst=0 during SCALE -> no reduced_rdy, outputs 0, busy=0; next sample processed normally.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// Shared types and helpers for the PWM audio sample path.
package pwm_audio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMag,
        StScale,
        StOut
    } scaler_state_e;

    // Channel tag width; a single-channel build still carries a 1-bit tag.
    function automatic int unsigned ch_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/pwm_sat_abs.sv
// Combinational absolute value; the most-negative input saturates to the largest positive magnitude.
module pwm_sat_abs #(
    parameter int unsigned IN_W = 16
) (
    input  logic [IN_W-1:0] x,
    output logic [IN_W-2:0] mag,
    output logic            sat
);

    localparam logic [IN_W-2:0] One = {{(IN_W-2){1'b0}}, 1'b1};

    always_comb begin
        sat = x[IN_W-1] && (x[IN_W-2:0] == '0);
        if (sat) begin
            mag = '1;
        end else if (x[IN_W-1]) begin
            // Low bits of -x; the sign bit of the negation is always 0 here.
            mag = (~x[IN_W-2:0]) + One;
        end else begin
            mag = x[IN_W-2:0];
        end
    end

endmodule

// File: rtl/pwm_sample_scaler.sv
// Multi-channel PCM attenuator/saturator feeding the per-channel PWM generators.
// Define PWM_SCALER_ROUND_EN to round the scaled magnitude half-up instead of truncating.
module pwm_sample_scaler
    import pwm_audio_pkg::*;
#(
    parameter int unsigned IN_W    = 16,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned NCH     = 2,
    parameter int unsigned SHIFT_W = 4,
    localparam int unsigned CH_W   = ch_width(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_W-1:0]        sound_in,
    input  logic [CH_W-1:0]        sound_ch,
    input  logic                   sound_rdy,
    input  logic [NCH*SHIFT_W-1:0] gain_shift,
    output logic                   busy,
    output logic [OUT_W-1:0]       reduced_out,
    output logic [CH_W-1:0]        reduced_ch,
    output logic                   reduced_rdy,
    output logic                   clip,
    output logic                   overrun
);

    scaler_state_e state_q, state_d;

    logic [IN_W-1:0]    sample_q;
    logic [CH_W-1:0]    ch_q;
    logic [SHIFT_W-1:0] shift_q;
    logic               sign_q;
    logic [IN_W-2:0]    mag_q;
    logic [OUT_W-1:0]   scaled_q;
    logic               clip_q;

    logic [OUT_W-1:0]   out_q;
    logic [CH_W-1:0]    out_ch_q;
    logic               out_rdy_q;
    logic               out_clip_q;
    logic               overrun_q;

    logic               ch_ok;
    logic               accept;
    logic [SHIFT_W-1:0] shift_sel;
    logic [IN_W-2:0]    abs_mag;
    logic               abs_sat;
    logic               shift_big;
    logic [IN_W-1:0]    mag_ext;
    logic [IN_W-1:0]    shifted;
    logic               sat_hit;
    logic [OUT_W-1:0]   scaled_mag;
    logic [OUT_W-1:0]   signed_out;

    // Tags outside the channel range are dropped without raising overrun.
    if (NCH == (1 << CH_W)) begin : g_ch_all
        assign ch_ok = 1'b1;
    end else begin : g_ch_chk
        assign ch_ok = (sound_ch < CH_W'(NCH));
    end

    assign busy   = (state_q != StIdle);
    assign accept = sound_rdy && ch_ok;

    always_comb begin
        shift_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sound_ch == CH_W'(k)) begin
                shift_sel = gain_shift[k*SHIFT_W +: SHIFT_W];
            end
        end
    end

    pwm_sat_abs #(
        .IN_W (IN_W)
    ) u_abs (
        .x   (sample_q),
        .mag (abs_mag),
        .sat (abs_sat)
    );

    if ((1 << SHIFT_W) > IN_W) begin : g_shift_chk
        assign shift_big = (shift_q >= SHIFT_W'(IN_W));
    end else begin : g_shift_fits
        assign shift_big = 1'b0;
    end

    always_comb begin
        mag_ext = {1'b0, mag_q};
        shifted = '0;
        if (!shift_big) begin
`ifdef PWM_SCALER_ROUND_EN
            // Magnitude is below 2^(IN_W-1), so adding the half-LSB bias cannot overflow IN_W bits.
            if (shift_q != '0) begin
                shifted = (mag_ext + (IN_W'(1) << (shift_q - SHIFT_W'(1)))) >> shift_q;
            end else begin
                shifted = mag_ext;
            end
`else
            shifted = mag_ext >> shift_q;
`endif
        end
    end

    if (OUT_W < IN_W) begin : g_narrow
        localparam logic [IN_W-1:0] MaxOut = IN_W'((64'd1 << (OUT_W - 1)) - 64'd1);
        always_comb begin
            sat_hit    = (shifted > MaxOut);
            scaled_mag = sat_hit ? OUT_W'(MaxOut) : shifted[OUT_W-1:0];
        end
    end else begin : g_wide
        assign sat_hit    = 1'b0;
        assign scaled_mag = OUT_W'(shifted);
    end

    // Two's complement negation of a zero magnitude is zero, so no -0 can appear.
    assign signed_out = sign_q ? (-scaled_q) : scaled_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StMag;
            StMag:   state_d = StScale;
            StScale: state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            sample_q   <= '0;
            ch_q       <= '0;
            shift_q    <= '0;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            scaled_q   <= '0;
            clip_q     <= 1'b0;
            out_q      <= '0;
            out_ch_q   <= '0;
            out_rdy_q  <= 1'b0;
            out_clip_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sound_rdy && busy) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sample_q <= sound_in;
                        ch_q     <= sound_ch;
                        shift_q  <= shift_sel;
                    end
                end
                StMag: begin
                    sign_q <= sample_q[IN_W-1];
                    mag_q  <= abs_mag;
                    clip_q <= abs_sat;
                end
                StScale: begin
                    scaled_q <= scaled_mag;
                    clip_q   <= clip_q | sat_hit;
                end
                StOut: begin
                end
                default: begin
                end
            endcase
            // Result registers stay at zero except for the single valid cycle.
            out_rdy_q  <= (state_q == StOut);
            out_q      <= (state_q == StOut) ? signed_out : '0;
            out_ch_q   <= (state_q == StOut) ? ch_q : '0;
            out_clip_q <= (state_q == StOut) && clip_q;
        end
    end

    assign reduced_out = out_q;
    assign reduced_ch  = out_ch_q;
    assign reduced_rdy = out_rdy_q;
    assign clip        = out_clip_q;
    assign overrun     = overrun_q;

endmodule
